axi_lite_master_bridge: RTL

- Converts the core's simple single-outstanding memory request port into AXI-Lite master transactions on an axi_lite_if.master bundle.
- Sits between the load/store unit (or fetch unit) and any AXI-Lite slave, e.g. the block RAM or peripherals.
- Handles exactly one transaction at a time: one read (AR then R) or one write (AW and W concurrently, then B).
- Returns read data and a response error flag to the core as a one-cycle pulse.

---
 rtl/axi_lite_pkg.sv | 20 ++
 rtl/axi_lite_if.sv | 57 +++++
 rtl/axi_lite_master_bridge.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the master bridge state encoding.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_type_e;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WREQ,
    WRESP,
    DONE
  } bridge_state_e;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite signal bundle with master and slave views.
interface axi_lite_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding core request port to AXI-Lite master bridge.
// One read (AR then R) or one write (AW and W together, then B) at a time;
// completion is reported as a one-cycle resp_valid pulse.
// Optional watchdog: define AXI_TIMEOUT_EN to abort hung transactions after
// TIMEOUT_CYCLES cycles in a single state (completes with resp_err = 1).
module axi_lite_master_bridge
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  axi_lite_if.master              m_axi
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("axi_lite_master_bridge: TIMEOUT_CYCLES must be at least 2");
  end

  bridge_state_e state;
  bridge_state_e state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  aw_done;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic ar_hs;
  logic r_hs;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic tmo_hit;

  // Handshakes are qualified by state so stray slave activity is ignored.
  assign ar_hs = (state == RADDR) && m_axi.arready;
  assign r_hs  = (state == RDATA) && m_axi.rvalid;
  assign aw_hs = (state == WREQ) && !aw_done && m_axi.awready;
  assign w_hs  = (state == WREQ) && !w_done && m_axi.wready;
  assign b_hs  = (state == WRESP) && m_axi.bvalid;

`ifdef AXI_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt;
  logic             busy;

  assign busy    = state inside {RADDR, RDATA, WREQ, WRESP};
  assign tmo_hit = busy && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts cycles spent in the current busy state, restarts on any state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state_next != state) begin
      tmo_cnt <= '0;
    end else if (busy) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and channel valid/ready decode; all outputs depend on state only,
  // never combinationally on a slave ready.
  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.bready  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = req_we ? WREQ : RADDR;
        end
      end
      RADDR: begin
        m_axi.arvalid = 1'b1;
        if (ar_hs) begin
          state_next = RDATA;
        end else if (tmo_hit) begin
          state_next = DONE;
        end
      end
      RDATA: begin
        m_axi.rready = 1'b1;
        if (r_hs) begin
          state_next = DONE;
        end else if (tmo_hit) begin
          state_next = DONE;
        end
      end
      WREQ: begin
        m_axi.awvalid = !aw_done;
        m_axi.wvalid  = !w_done;
        // Leave as soon as both channels are complete, including handshakes in this cycle.
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_next = WRESP;
        end else if (tmo_hit) begin
          state_next = DONE;
        end
      end
      WRESP: begin
        m_axi.bready = 1'b1;
        if (b_hs) begin
          state_next = DONE;
        end else if (tmo_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture: payload is frozen for the whole transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if ((state == IDLE) && req_valid) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end
  end

  // Per-channel write completion flags, cleared on return to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n || (state_next == IDLE)) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        w_done <= 1'b1;
      end
    end
  end

  // Completion data and error flag; a real handshake takes priority over the watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (r_hs) begin
      rdata_q <= m_axi.rdata;
      err_q   <= (m_axi.rresp != RESP_OKAY);
    end else if (b_hs) begin
      rdata_q <= '0;
      err_q   <= (m_axi.bresp != RESP_OKAY);
    end else if (tmo_hit) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end
  end

  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;

  assign m_axi.araddr = addr_q;
  assign m_axi.arprot = '0;
  assign m_axi.awaddr = addr_q;
  assign m_axi.awprot = '0;
  assign m_axi.wdata  = wdata_q;
  assign m_axi.wstrb  = wstrb_q;

endmodule
